// File: rtl/wb_spi_master_pkg.sv
// rtl/wb_spi_master_pkg.sv - register offsets, status bit indices and FSM encoding for wb_spi_master
package wb_spi_master_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DIV  = 2'd1;
    localparam logic [1:0] REG_TX   = 2'd2;
    localparam logic [1:0] REG_RX   = 2'd3;

    localparam int ST_BUSY       = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_TX_DROPPED = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_CTRL_LSB   = 4;

    localparam int CTRL_SS_MANUAL = 0;
    localparam int CTRL_SS_AUTO   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - half-period timer for the SPI master; phase 0 half ends give fall_tick, phase 1 half ends give rise_tick
module spi_sck_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 half_done,
    output logic                 rise_tick,
    output logic                 fall_tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 phase;

    // The divider is captured at frame start so a DIV write mid-frame only affects the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_lat <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
        end else if (start) begin
            div_lat <= div;
            cnt     <= '0;
            phase   <= 1'b0;
        end else if (en) begin
            if (cnt == div_lat) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + DIV_ONE;
            end
        end
    end

    assign half_done = en & (cnt == div_lat);
    assign rise_tick = half_done & phase;
    assign fall_tick = half_done & ~phase;

endmodule

// File: rtl/wb_spi_master.sv
// rtl/wb_spi_master.sv - Wishbone slave driving an SPI bus as master, mode 0, MSB first, 16-bit frames
module wb_spi_master #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_ss
);
    import wb_spi_master_pkg::*;

    localparam int                   CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOP   = CNT_WIDTH'(DATA_WIDTH - 1);

    spi_state_t            state;
    logic [1:0]            ctrl;
    logic [DIV_WIDTH-1:0]  div;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic                  rx_valid;
    logic                  tx_dropped;
    logic                  rx_overrun;

    logic                  access;
    logic                  wr;
    logic                  rd;
    logic [1:0]            reg_sel;
    logic                  frame_active;
    logic                  tx_start;
    logic                  hold_done;
    logic                  half_done;
    logic                  rise_tick;
    logic                  fall_tick;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_bits;

    // All register side effects land on the edge that raises ack, so the ack cycle already shows them.
    assign access       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr           = access & wb_we_i;
    assign rd           = access & ~wb_we_i;
    assign reg_sel      = wb_adr_i[1:0];
    assign frame_active = (state != S_IDLE);
    assign tx_start     = wr & (reg_sel == REG_TX) & (state == S_IDLE);
    assign hold_done    = (state == S_HOLD) & half_done;
    assign unused_bits  = ^{wb_sel_i, wb_adr_i[ADDR_WIDTH-1:2]};

    assign spi_ss = ~(ctrl[CTRL_SS_MANUAL] | (ctrl[CTRL_SS_AUTO] & frame_active));

    spi_sck_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .en        (frame_active),
        .div       (div),
        .half_done (half_done),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_mux[ST_BUSY]            = frame_active;
                rd_mux[ST_RX_VALID]        = rx_valid;
                rd_mux[ST_TX_DROPPED]      = tx_dropped;
                rd_mux[ST_RX_OVERRUN]      = rx_overrun;
                rd_mux[ST_CTRL_LSB +: 2]   = ctrl;
            end
            REG_DIV:  rd_mux[DIV_WIDTH-1:0] = div;
            REG_RX:   rd_mux = rx_data;
            default:  rd_mux = '0;
        endcase
    end

    // Frame sequencer: SETUP is one half-period with bit 15 on mosi, then 16 low/high bit periods, then HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        state    <= S_SETUP;
                        tx_sh    <= wb_dat_i;
                        spi_mosi <= wb_dat_i[DATA_WIDTH-1];
                        bit_cnt  <= CNT_TOP;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (rise_tick) begin
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[DATA_WIDTH-2:0], spi_miso};
                    end
                    if (fall_tick) begin
                        spi_sck <= 1'b0;
                        if (bit_cnt == '0) begin
                            state    <= S_HOLD;
                            spi_mosi <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt - CNT_ONE;
                            tx_sh    <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
                            spi_mosi <= tx_sh[DATA_WIDTH-2];
                        end
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-to-clear is written first so a sticky set or a completing frame on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            ctrl       <= 2'b00;
            div        <= DIV_WIDTH'(DEFAULT_DIV);
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_dropped <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            wb_ack_o <= access;
            if (rd) begin
                wb_dat_o <= rd_mux;
            end
            if (wr && reg_sel == REG_CTRL) begin
                ctrl <= wb_dat_i[1:0];
            end
            if (wr && reg_sel == REG_DIV) begin
                div <= wb_dat_i[DIV_WIDTH-1:0];
            end
            if (rd && reg_sel == REG_CTRL) begin
                tx_dropped <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (rd && reg_sel == REG_RX) begin
                rx_valid <= 1'b0;
            end
            if (wr && reg_sel == REG_TX && frame_active) begin
                tx_dropped <= 1'b1;
            end
            if (hold_done) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                if (rx_valid) begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// tb/tb_wb_spi_master.sv - self-checking bench for wb_spi_master against a frame-level behavioural model
module tb_wb_spi_master;

    logic        clk;
    logic        rst;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [13:0] wb_adr_i;
    logic [1:0]  wb_sel_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_ss;
    logic        loop;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    // Model: registers plus the single frame that can be in flight, described by its cycle window.
    logic [1:0]  ctrl_m;
    int          div_m;
    bit          rxv_m, ovr_m, drop_m;
    logic [15:0] rx_m;
    bit          fr_act, fr_loop;
    int          fr_start, fr_end, fr_h;
    logic [15:0] fr_data;

    int   ss_low_cnt = 0, rise_cnt = 0, mosi_hi_cnt = 0, last_rise = 0, rise_gap = 0;
    logic prev_sck = 1'b0;

    wb_spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss   (spi_ss)
    );

    assign spi_miso = loop ? spi_mosi : ~spi_mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        ctrl_m = 2'b00; div_m = 4; rxv_m = 0; ovr_m = 0; drop_m = 0; rx_m = 16'h0;
        fr_act = 0; fr_loop = 0; fr_start = 0; fr_end = 0; fr_h = 1; fr_data = 16'h0;
    endtask

    task automatic finish_frame(output bit ovr_set);
        ovr_set = rxv_m;
        if (rxv_m) ovr_m = 1;
        rx_m   = fr_loop ? fr_data : ~fr_data;
        rxv_m  = 1;
        fr_act = 0;
    endtask

    // Effects of one access whose ack-raising edge is posedge number e.
    task automatic model_access(input int e, input bit we, input int adr, input int wd, output int rd);
        bit busy, fin_now, ovr_new;
        int a;
        a = adr % 4;
        fin_now = 0; ovr_new = 0;
        if (fr_act && fr_end < e) finish_frame(ovr_new);
        ovr_new = 0;
        busy = fr_act && (e <= fr_end);
        case (a)
            0: rd = (int'(ctrl_m) << 4) | (int'(ovr_m) << 3) | (int'(drop_m) << 2) | (int'(rxv_m) << 1) | int'(busy);
            1: rd = div_m;
            2: rd = 0;
            default: rd = int'(rx_m);
        endcase
        if (fr_act && fr_end == e) begin
            finish_frame(ovr_new);
            fin_now = 1;
        end
        if (!we && a == 0) begin
            drop_m = 0;
            if (!ovr_new) ovr_m = 0;
        end
        if (!we && a == 3 && !fin_now) rxv_m = 0;
        if (we) begin
            case (a)
                0: ctrl_m = wd[1:0];
                1: div_m = wd & 255;
                2: begin
                    if (busy) drop_m = 1;
                    else begin
                        fr_act = 1; fr_loop = loop; fr_start = e; fr_h = div_m + 1;
                        fr_end = e + 34 * fr_h; fr_data = wd[15:0];
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Expected pins at cycle n from the frame window: half-period k, sck high on even k in 2..32.
    task automatic compare_outputs();
        int  t, k;
        bit  in_fr;
        logic e_sck, e_mosi, e_ss;
        in_fr  = (cyc >= fr_start) && (cyc < fr_end);
        e_sck  = 1'b0;
        e_mosi = 1'b0;
        if (in_fr) begin
            t = cyc - fr_start;
            k = t / fr_h;
            e_sck = (k >= 2) && (k <= 32) && (k % 2 == 0);
            if (k == 0) e_mosi = fr_data[15];
            else if (k <= 32) e_mosi = fr_data[15 - (k - 1) / 2];
        end
        e_ss = !(ctrl_m[0] || (ctrl_m[1] && in_fr));
        check("sck", spi_sck, e_sck);
        check("mosi", spi_mosi, e_mosi);
        check("ss", spi_ss, e_ss);
        if (!spi_ss) ss_low_cnt++;
        if (spi_mosi) mosi_hi_cnt++;
        if (spi_sck && !prev_sck) begin
            rise_cnt++;
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
        end
        prev_sck = spi_sck;
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input bit we, input int adr, input int wd, output int rd);
        int exp_rd;
        wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = we;
        wb_adr_i = 14'(adr); wb_dat_i = 16'(wd);
        step();
        model_access(cyc, we, adr, wd, exp_rd);
        check("ack", wb_ack_o, 1);
        rd = int'(wb_dat_o);
        if (!we) check("rdata", wb_dat_o, exp_rd);
        wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        step();
        check("ack_single", wb_ack_o, 0);
    endtask

    task automatic wait_frame_done();
        while (cyc <= fr_end + 1) step();
    endtask

    initial begin
        int rd, base_ss, base_rise, base_mosi, op;
        rst = 1; wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
        wb_adr_i = 14'h0; wb_sel_i = 2'b11; wb_dat_i = 16'h0; loop = 1;
        model_reset();
        repeat (3) step();
        rst = 0;
        repeat (2) step();

        check("ack_reset", wb_ack_o, 0);
        wb(0, 1, 0, rd); check("div_reset", rd, 4);
        wb(0, 0, 0, rd); check("status_reset", rd, 0);

        wb(1, 0, 2, rd); wb(1, 1, 0, rd);
        base_ss = ss_low_cnt; base_rise = rise_cnt;
        wb(1, 2, 16'hA5C3, rd);
        wait_frame_done();
        check("loop_ss_window", ss_low_cnt - base_ss, 34);
        check("loop_rises", rise_cnt - base_rise, 16);
        wb(0, 0, 0, rd); check("loop_rx_valid_set", (rd >> 1) & 1, 1);
        wb(0, 3, 0, rd); check("loop_rx", rd, 16'hA5C3);
        wb(0, 0, 0, rd); check("loop_rx_valid_clr", (rd >> 1) & 1, 0);

        wb(1, 1, 3, rd);
        base_ss = ss_low_cnt; base_mosi = mosi_hi_cnt;
        wb(1, 2, 16'h0001, rd);
        repeat (20) step();
        wb(0, 0, 0, rd); check("div_busy", rd & 1, 1);
        wait_frame_done();
        check("div_ss_window", ss_low_cnt - base_ss, 136);
        check("div_sck_period", rise_gap, 8);
        check("div_mosi_high", mosi_hi_cnt - base_mosi, 8);
        wb(0, 3, 0, rd); check("div_rx", rd, 16'h0001);

        wb(1, 1, 1, rd);
        wb(1, 2, 16'h5A0F, rd);
        repeat (10) step();
        wb(1, 2, 16'h1234, rd);
        wait_frame_done();
        wb(0, 0, 0, rd); check("drop_set", (rd >> 2) & 1, 1);
        wb(0, 0, 0, rd); check("drop_clr", (rd >> 2) & 1, 0);
        wb(0, 3, 0, rd); check("drop_rx", rd, 16'h5A0F);

        wb(1, 1, 0, rd);
        wb(1, 2, 16'h1111, rd); wait_frame_done();
        wb(1, 2, 16'h2222, rd); wait_frame_done();
        wb(0, 0, 0, rd); check("ovr_set", (rd >> 3) & 1, 1);
        wb(0, 3, 0, rd); check("ovr_rx", rd, 16'h2222);

        loop = 0;
        wb(1, 2, 16'h3C96, rd); wait_frame_done();
        wb(0, 3, 0, rd); check("inv_rx", rd, 16'hC369);

        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: wb(1, 0, $urandom_range(0, 3), rd);
                1: wb(1, 1, $urandom_range(0, 3), rd);
                2, 3: begin
                    if (cyc > fr_end) loop = 1'($urandom_range(0, 1));
                    wb(1, 2, $urandom_range(0, 65535), rd);
                end
                4, 5, 6: wb(0, $urandom_range(0, 16383), 0, rd);
                7: wb(1, 3, $urandom_range(0, 65535), rd);
                default: repeat ($urandom_range(1, 40)) step();
            endcase
        end
        wait_frame_done();

        loop = 1;
        wb(1, 0, 2, rd); wb(1, 1, 0, rd); wb(1, 2, 16'hFFFF, rd);
        repeat (17) step();
        check("abort_pre_sck", spi_sck, 1);
        #2;
        rst = 1;
        model_reset();
        #1;
        check("abort_ss", spi_ss, 1);
        check("abort_sck", spi_sck, 0);
        check("abort_mosi", spi_mosi, 0);
        check("abort_ack", wb_ack_o, 0);
        repeat (2) step();
        rst = 0;
        step();
        wb(0, 1, 0, rd); check("abort_div", rd, 4);
        wb(0, 0, 0, rd); check("abort_status", rd, 0);
        wb(1, 0, 1, rd);
        repeat (5) step();
        check("manual_ss", spi_ss, 0);
        check("manual_sck", spi_sck, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_spi_master.md
Name: wb_spi_master

Overview:
- Wishbone slave peripheral that acts as an SPI bus master, SPI mode 0, MSB first, fixed 16-bit frames.
- It is the master end of the same SPI link that the host-facing SPI slave bridge serves.
- Sits on the conbus slave6 window (0x3000). It drives an external SPI device from registers written over Wishbone by the host.

Parameters:
- ADDR_WIDTH, 14, Wishbone address width.
- DATA_WIDTH, 16, Wishbone data width and SPI frame length.
- DIV_WIDTH, 8, width of the clock-divider register.
- DEFAULT_DIV, 4, reset value of the DIV register.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wb_stb_i  in  1  Wishbone strobe.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  ADDR_WIDTH  word address; only bits [1:0] are decoded.
- wb_sel_i  in  2  byte selects; ignored, all writes are full-word.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data, registered.
- wb_ack_o  out  1  acknowledge.
- spi_sck  out  1  SPI clock, idle low.
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  master-in data.
- spi_ss  out  1  slave select, active low.

Behaviour:
- Reset values:
  - wb_ack_o=0, wb_dat_o=0.
  - spi_sck=0, spi_mosi=0, spi_ss=1.
  - DIV=DEFAULT_DIV, CTRL=0, RX=0, all status bits 0, FSM=IDLE.
- Wishbone access:
  - wb_ack_o pulses high one cycle after the first cycle with stb&cyc=1, for exactly one cycle.
  - No new ack is issued in the cycle it is high (one ack per access).
  - Reads return wb_dat_o together with the ack.
- Register map, by adr[1:0]:
  - 0 CTRL/STATUS.
    - Write: bit0 ss_manual (forces ss low while 1), bit1 ss_auto (ss is driven low only during frames).
    - Read: bit0 busy, bit1 rx_valid, bit2 tx_dropped, bit3 rx_overrun, bits[5:4] the CTRL value.
    - Reading clears bits 2 and 3 in the ack cycle.
  - 1 DIV: SCK half-period h = DIV+1 clk cycles.
  - 2 TX: a write while IDLE loads the shifter and starts a frame; a write while busy is discarded and sets tx_dropped.
  - 3 RX: read returns the last completed frame and clears rx_valid. A read while busy returns the previous frame.
- spi_ss:
  - spi_ss = ~(ss_manual | (ss_auto & frame_active)).
  - frame_active is high from SETUP entry to HOLD exit.
- FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE:
  - IDLE: busy=0. A TX write moves to SETUP on the ack cycle.
  - SETUP: lasts h cycles; spi_mosi = bit15.
  - SHIFT: 16 bit periods, each a low half (h cycles) then a high half (h cycles).
    - spi_miso is sampled into the RX shifter on the rising edge.
    - spi_mosi updates to the next bit on the falling edge.
    - The bit counter runs 15..0.
  - HOLD: lasts h cycles with spi_sck=0, then the FSM returns to IDLE.
  - On HOLD exit: RX register is updated and rx_valid set. If rx_valid was already 1, rx_overrun is also set.
- Timing: busy stays high for exactly 34*h cycles after the TX ack cycle.
- DIV written while busy takes effect on the next frame; h is latched at SETUP entry.
- Simultaneous events:
  - RX read in the same cycle as HOLD exit: the new data wins and rx_valid ends at 1.
  - STATUS read in the same cycle a sticky bit sets: the set wins.
- Reset asserted mid-frame: all outputs go immediately (asynchronously) to their reset values, and the frame is abandoned.

Decomposition:
- Package wb_spi_master_pkg holds the register offsets (CTRL=0, DIV=1, TX=2, RX=3), the status bit indices, and the FSM state encoding.
- One natural sub-module, spi_sck_gen. It contains the h-cycle half-period counter and emits rise_tick/fall_tick and half-period-done pulses. It is enabled only outside IDLE and restarts at SETUP entry.

Test Plan:
- Reset check: assert rst mid-simulation -> wb_ack_o=0, spi_ss=1, spi_sck=0, DIV reads 4, STATUS reads 0.
- Loopback: tie spi_miso to spi_mosi, CTRL=2, DIV=0, write TX=0xA5C3.
  - busy high for 34 cycles.
  - spi_ss low for exactly that window.
  - 16 sck rising edges; RX reads 0xA5C3.
  - rx_valid=1 before the read and 0 after it.
- Divider: set DIV=3, then write TX=0x0001 -> sck period is 8 clk cycles, busy lasts 136 cycles, mosi is high only during the final bit period.
- Write while busy: write TX=0x1234 during a frame -> frame data unchanged, STATUS bit2=1; a second STATUS read returns bit2=0.
- Overrun: complete two frames without reading RX -> STATUS bit3=1, RX holds the second frame.
- Abort and manual select: reset in bit 7 of a frame -> ss=1 and sck=0 within the same cycle. After reset, CTRL=1 -> ss=0 with no frame and sck idle.
